// File: rtl/miic_pkg.sv
// Shared definitions for the MIIC operation queue: command field layout,
// widths and FSM state encodings.
package miic_pkg;

    localparam int CMD_W         = 11;
    localparam int DATA_W        = 8;
    localparam int CMD_START_BIT = 10;
    localparam int CMD_STOP_BIT  = 9;
    localparam int CMD_RNW_BIT   = 8;
    localparam int CMD_DATA_MSB  = 7;
    localparam int CMD_DATA_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } opq_state_e;

    typedef struct packed {
        logic              start;
        logic              stop;
        logic              rnw;
        logic [DATA_W-1:0] wr_data;
    } miic_cmd_t;

endpackage

// File: rtl/miic_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, count,
// full and empty. A pop at full frees the slot for a push in the same cycle.
module miic_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop  = rd_en_i && !empty_q;
    assign do_push = wr_en_i && (!full_q || do_pop);

    // Head register keeps its old value when the FIFO drains, so a pop on
    // empty leaves rd_data untouched.
    always_comb begin
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        head_d = head_q;
        if (cnt_d != '0) begin
            if ((cnt_q - CW'(do_pop)) == '0) head_d = wr_data_i;
            else                             head_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_q + AW'(do_push);
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign rd_data_o = head_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/miic_op_queue.sv
// Command/read-data queue in front of a byte engine: issues one op at a time
// and collects read data. Optional MIIC_OPQ_STATS_EN adds ops_done/nack_cnt.
module miic_op_queue
    import miic_pkg::*;
#(
    parameter  int CMD_DEPTH = 16,
    parameter  int RD_DEPTH  = 16,
    localparam int CCW       = $clog2(CMD_DEPTH) + 1,
    localparam int RCW       = $clog2(RD_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_wr_en,
    input  logic [CMD_W-1:0]  cmd_wr_data,
    output logic              cmd_full,
    output logic [CCW-1:0]    cmd_count,
    input  logic              rd_rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic [RCW-1:0]    rd_count,
    output logic              busy,
    output logic              err,
    output logic              ovf,
    input  logic              err_clr,
    output logic              op_valid,
    output logic              op_start,
    output logic              op_stop,
    output logic              op_rnw,
    output logic [DATA_W-1:0] op_wr_data,
    input  logic [DATA_W-1:0] op_rd_data,
    input  logic              op_ack,
    input  logic              op_err
`ifdef MIIC_OPQ_STATS_EN
    ,
    output logic [15:0]       ops_done,
    output logic [7:0]        nack_cnt
`endif
);

    opq_state_e       state_q;
    miic_cmd_t        op_q, cmd_head;
    logic [CMD_W-1:0] cmd_head_raw;
    logic             op_valid_q, busy_q, err_q, ovf_q;
    logic             cmd_empty, rd_full;
    logic             accept, cmd_push, launch, busy_d;
    logic [CCW-1:0]   cmd_count_n;

    // Acks are only honoured in WAIT_ACK; the engine may pulse op_ack freely.
    assign accept   = (state_q == ST_WAIT_ACK) && op_ack;
    assign cmd_push = cmd_wr_en && (!cmd_full || accept);
    // A read leaves IDLE only with a free read slot; nothing else fills it.
    assign launch   = (state_q == ST_IDLE) && !cmd_empty && (!cmd_head.rnw || !rd_full);

    assign cmd_head = '{start:   cmd_head_raw[CMD_START_BIT],
                        stop:    cmd_head_raw[CMD_STOP_BIT],
                        rnw:     cmd_head_raw[CMD_RNW_BIT],
                        wr_data: cmd_head_raw[CMD_DATA_MSB:CMD_DATA_LSB]};

    assign cmd_count_n = cmd_count + CCW'(cmd_push) - CCW'(accept);
    assign busy_d      = launch || (state_q == ST_ISSUE) ||
                         ((state_q == ST_WAIT_ACK) && !op_ack) || (cmd_count_n != '0);

    miic_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (cmd_wr_en),
        .wr_data_i (cmd_wr_data),
        .rd_en_i   (accept),
        .rd_data_o (cmd_head_raw),
        .full_o    (cmd_full),
        .empty_o   (cmd_empty),
        .count_o   (cmd_count)
    );

    miic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept && op_q.rnw),
        .wr_data_i (op_rd_data),
        .rd_en_i   (rd_rd_en),
        .rd_data_o (rd_data),
        .full_o    (rd_full),
        .empty_o   (rd_empty),
        .count_o   (rd_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            busy_q <= busy_d;
            // Sticky flags: a new event outranks a coincident clear.
            if (accept && op_err) err_q <= 1'b1;
            else if (err_clr)     err_q <= 1'b0;
            if (cmd_wr_en && !cmd_push) ovf_q <= 1'b1;
            else if (err_clr)           ovf_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q    <= ST_ISSUE;
                        op_q       <= cmd_head;
                        op_valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (op_ack) begin
                        state_q    <= ST_IDLE;
                        op_q       <= '0;
                        op_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_valid   = op_valid_q;
    assign op_start   = op_q.start;
    assign op_stop    = op_q.stop;
    assign op_rnw     = op_q.rnw;
    assign op_wr_data = op_q.wr_data;
    assign busy       = busy_q;
    assign err        = err_q;
    assign ovf        = ovf_q;

`ifdef MIIC_OPQ_STATS_EN
    logic [15:0] ops_done_q;
    logic [7:0]  nack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_q <= '0;
            nack_q     <= '0;
        end else begin
            if (accept)       ops_done_q <= (ops_done_q == 16'hFFFF) ? ops_done_q : ops_done_q + 16'd1;
            else if (err_clr) ops_done_q <= '0;
            if (accept && op_err) nack_q <= (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
            else if (err_clr)     nack_q <= '0;
        end
    end

    assign ops_done = ops_done_q;
    assign nack_cnt = nack_q;
`endif

endmodule

// File: tb/tb_miic_op_queue.sv
// Scoreboarded bench for miic_op_queue: random and directed stimulus, a
// byte-engine model, and a monitor checking issued ops and popped read data.
module tb_miic_op_queue;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_wr_en = 1'b0;
    logic [10:0] cmd_wr_data = '0;
    logic        cmd_full;
    logic [4:0]  cmd_count;
    logic        rd_rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic [4:0]  rd_count;
    logic        busy, err, ovf;
    logic        err_clr = 1'b0;
    logic        op_valid, op_start, op_stop, op_rnw;
    logic [7:0]  op_wr_data;
    logic [7:0]  op_rd_data = '0;
    logic        op_ack = 1'b0, op_err = 1'b0;
`ifdef MIIC_OPQ_STATS_EN
    logic [15:0] ops_done;
    logic [7:0]  nack_cnt;
`endif

    int          errors = 0, checks = 0, issue_cnt = 0;
    logic [10:0] exp_cmd[$];
    logic [7:0]  exp_rd[$];
    logic        exp_err = 1'b0;
    int          eng_mode = 0, eng_dly = 0, eng_err_pct = 0;
    logic        eng_fix = 1'b0, chk_len = 1'b0;
    logic [7:0]  eng_data = '0;

    always #5 clk = ~clk;

    miic_op_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_wr_en   (cmd_wr_en),
        .cmd_wr_data (cmd_wr_data),
        .cmd_full    (cmd_full),
        .cmd_count   (cmd_count),
        .rd_rd_en    (rd_rd_en),
        .rd_data     (rd_data),
        .rd_empty    (rd_empty),
        .rd_count    (rd_count),
        .busy        (busy),
        .err         (err),
        .ovf         (ovf),
        .err_clr     (err_clr),
        .op_valid    (op_valid),
        .op_start    (op_start),
        .op_stop     (op_stop),
        .op_rnw      (op_rnw),
        .op_wr_data  (op_wr_data),
        .op_rd_data  (op_rd_data),
        .op_ack      (op_ack),
        .op_err      (op_err)
`ifdef MIIC_OPQ_STATS_EN
        ,
        .ops_done    (ops_done),
        .nack_cnt    (nack_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] c);
        cmd_wr_en   = 1'b1;
        cmd_wr_data = c;
        if (!cmd_full) exp_cmd.push_back(c);
        step();
        cmd_wr_en = 1'b0;
    endtask

    task automatic drain(input bit pop_rd, input string name);
        int n;
        for (n = 0; n < 3000; n++) begin
            if (!busy && (!pop_rd || rd_empty)) break;
            rd_rd_en = pop_rd && !rd_empty;
            step();
        end
        rd_rd_en = 1'b0;
        chk({name, "_timeout"}, 32'(n >= 3000), 0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        for (n = 0; n < 200 && !op_valid; n++) step();
        chk({name, "_valid_timeout"}, 32'(n >= 200), 0);
    endtask

    // Monitor: every new op must match the oldest queued command and stay
    // stable while valid; every accepted read pop must match the oldest datum.
    initial begin : monitor
        logic        pv;
        int          vlen;
        logic [10:0] cur;
        pv = 1'b0; vlen = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0; vlen = 0;
                continue;
            end
            if (op_valid && !pv) begin
                issue_cnt++;
                vlen = 1;
                cur  = {op_start, op_stop, op_rnw, op_wr_data};
                if (exp_cmd.size() == 0) chk("issue_unexpected", 32'(cur), 32'h7FF_FFFF);
                else                     chk("issue_fields", 32'(cur), 32'(exp_cmd.pop_front()));
            end else if (op_valid) begin
                vlen++;
                chk("op_stable", 32'({op_start, op_stop, op_rnw, op_wr_data}), 32'(cur));
            end else if (pv && chk_len) begin
                chk("valid_len", 32'(vlen), 2);
            end
            if (rd_rd_en && !rd_empty) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rd_data), 32'h1FF);
                else                    chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            pv = op_valid;
        end
    end

    // Byte-engine model: acks a pending op after a delay and records what
    // the queue should deliver back.
    initial begin : engine
        int   d;
        logic rnw;
        forever begin
            @(negedge clk);
            if (eng_mode == 1 && rst_n && op_valid) begin
                d = (eng_dly > 0) ? eng_dly : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1;
                if (eng_mode != 1 || !rst_n || !op_valid) continue;
                rnw        = op_rnw;
                op_rd_data = eng_fix ? eng_data : 8'($urandom);
                op_err     = (int'($urandom_range(0, 99)) < eng_err_pct);
                op_ack     = 1'b1;
                if (rnw)    exp_rd.push_back(op_rd_data);
                if (op_err) exp_err = 1'b1;
                @(posedge clk);
                #1;
                op_ack = 1'b0;
                op_err = 1'b0;
                @(negedge clk);
                chk("ack_drops_valid", 32'(op_valid), 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        logic [10:0] c;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_cmd_count", 32'(cmd_count), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_rd_empty", 32'(rd_empty), 1);
        chk("rst_cmd_full", 32'(cmd_full), 0);
        chk("rst_flags", 32'({busy, err, ovf}), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_op_fields", 32'({op_start, op_stop, op_rnw, op_wr_data}), 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Two ops in order, read data returned, latency N+2.
        eng_mode = 1; eng_dly = 5; eng_fix = 1'b1; eng_data = 8'h5C;
        cmd_wr_en = 1'b1; cmd_wr_data = {1'b1, 1'b0, 1'b0, 8'hA0};
        exp_cmd.push_back(cmd_wr_data);
        step();
        cmd_wr_data = {1'b0, 1'b1, 1'b1, 8'h00};
        exp_cmd.push_back(cmd_wr_data);
        @(negedge clk);
        chk("lat_n1_valid", 32'(op_valid), 0);
        chk("lat_n1_busy", 32'(busy), 1);
        step();
        cmd_wr_en = 1'b0;
        @(negedge clk);
        chk("lat_n2_valid", 32'(op_valid), 1);
        chk("lat_n2_fields", 32'({op_start, op_stop, op_rnw, op_wr_data}), 32'h4A0);
        step();
        drain(0, "t1");
        chk("t1_rd_data", 32'(rd_data), 32'h5C);
        chk("t1_rd_count", 32'(rd_count), 1);
        chk("t1_err", 32'(err), 0);
        drain(1, "t1pop");
        chk("t1_rd_empty", 32'(rd_empty), 1);

        // Fill command FIFO with the engine stalled; overflow and clear.
        eng_mode = 0; eng_dly = 0; eng_fix = 1'b0;
        for (int i = 0; i < 16; i++) push({1'b0, 1'(i), 1'b0, 8'($urandom)});
        chk("t2_count16", 32'(cmd_count), 16);
        chk("t2_full", 32'(cmd_full), 1);
        chk("t2_ovf_pre", 32'(ovf), 0);
        cmd_wr_en = 1'b1; cmd_wr_data = 11'h055; err_clr = 1'b1;
        step();
        cmd_wr_en = 1'b0; err_clr = 1'b0;
        chk("t2_ovf_set_wins", 32'(ovf), 1);
        chk("t2_count_kept", 32'(cmd_count), 16);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t2_ovf_cleared", 32'(ovf), 0);
        // Push at full coincident with the ack that pops the head.
        cmd_wr_en = 1'b1; cmd_wr_data = 11'h0C3; exp_cmd.push_back(11'h0C3);
        op_ack = 1'b1;
        step();
        cmd_wr_en = 1'b0; op_ack = 1'b0;
        chk("t2_full_pushpop_count", 32'(cmd_count), 16);
        chk("t2_full_pushpop_ovf", 32'(ovf), 0);
        chk("t2_ack_valid", 32'(op_valid), 0);
        eng_mode = 1;
        drain(1, "t2");
        chk("t2_empty", 32'(cmd_count), 0);

        // Read FIFO full blocks a read command until a slot frees.
        for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < 100 && cmd_full; w++) step();
            push({1'b0, 1'b0, 1'b1, 8'($urandom)});
        end
        drain(0, "t3fill");
        chk("t3_rd_full_count", 32'(rd_count), 16);
        push({1'b1, 1'b1, 1'b1, 8'h3C});
        repeat (6) step();
        chk("t3_blocked_valid", 32'(op_valid), 0);
        chk("t3_blocked_busy", 32'(busy), 1);
        chk("t3_blocked_count", 32'(cmd_count), 1);
        rd_rd_en = 1'b1;
        step();
        rd_rd_en = 1'b0;
        @(negedge clk);
        chk("t3_p1_valid", 32'(op_valid), 0);
        step();
        @(negedge clk);
        chk("t3_p2_valid", 32'(op_valid), 1);
        step();
        drain(1, "t3");

        // op_ack held high: one accept per ISSUE/WAIT_ACK pair.
        eng_mode = 0; op_ack = 1'b1; chk_len = 1'b1;
        base = issue_cnt;
        for (int i = 0; i < 3; i++) push({1'b0, 1'b0, 1'b0, 8'($urandom)});
        drain(0, "t4");
        repeat (2) step();
        op_ack = 1'b0; chk_len = 1'b0;
        chk("t4_issues", 32'(issue_cnt - base), 3);
        chk("t4_count", 32'(cmd_count), 0);

        // NACK coincident with err_clr: set wins.
        push({1'b0, 1'b1, 1'b0, 8'h77});
        wait_valid("t5");
        step();
        op_ack = 1'b1; op_err = 1'b1; err_clr = 1'b1;
        step();
        op_ack = 1'b0; op_err = 1'b0; err_clr = 1'b0;
        chk("t5_err_set_wins", 32'(err), 1);
        chk("t5_valid", 32'(op_valid), 0);
`ifdef MIIC_OPQ_STATS_EN
        chk("t5_nack_cnt", 32'(nack_cnt), 1);
`endif
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t5_err_cleared", 32'(err), 0);
        exp_err = 1'b0;

        // Randomized traffic with random NACKs and read pops.
        eng_mode = 1; eng_err_pct = 15;
        for (int i = 0; i < 300; i++) begin
            rd_rd_en = !rd_empty && ($urandom_range(0, 2) == 0);
            if (!cmd_full && $urandom_range(0, 1) == 1) begin
                c = 11'($urandom);
                cmd_wr_en = 1'b1; cmd_wr_data = c; exp_cmd.push_back(c);
            end else begin
                cmd_wr_en = 1'b0;
            end
            step();
        end
        cmd_wr_en = 1'b0; rd_rd_en = 1'b0;
        drain(1, "rand");
        chk("rand_err", 32'(err), 32'(exp_err));
        chk("rand_cmd_left", 32'(exp_cmd.size()), 0);
        chk("rand_rd_left", 32'(exp_rd.size()), 0);

        // Reset while an op is in flight with more queued.
        eng_mode = 0; eng_err_pct = 0;
        for (int i = 0; i < 4; i++) push({1'b0, 1'b0, 1'b0, 8'($urandom)});
        step();
        chk("t7_inflight", 32'(op_valid), 1);
        chk("t7_count", 32'(cmd_count), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(op_valid), 0);
        chk("t7_rst_count", 32'(cmd_count), 0);
        chk("t7_rst_flags", 32'({busy, err, ovf, cmd_full}), 0);
        chk("t7_rst_rd_empty", 32'(rd_empty), 1);
        chk("t7_rst_fields", 32'({op_start, op_stop, op_rnw, op_wr_data}), 0);
        exp_cmd.delete();
        @(negedge clk) rst_n = 1'b1;
        step();
        eng_mode = 1;
        cmd_wr_en = 1'b1; cmd_wr_data = {1'b1, 1'b0, 1'b1, 8'h12};
        exp_cmd.push_back(cmd_wr_data);
        step();
        cmd_wr_en = 1'b0;
        @(negedge clk);
        chk("t7_lat_n1", 32'(op_valid), 0);
        step();
        @(negedge clk);
        chk("t7_lat_n2", 32'(op_valid), 1);
        step();
        drain(1, "t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miic_op_queue.md
MIIC_OP_QUEUE -- requirements
Module: miic_op_queue

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 16, command FIFO entries (power of 2, 2..256).
REQ-002 SHALL have parameter RD_DEPTH, default 16, read-data FIFO entries (power of 2, 2..256).
REQ-003 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: cmd_wr_en  in  1  push strobe; cmd_wr_data  in  11  {start[10], stop[9], rnw[8], wr_data[7:0]}; cmd_full  out  1; cmd_count  out  log2(CMD_DEPTH)+1  occupancy.
REQ-005 SHALL have ports: rd_rd_en  in  1  pop strobe; rd_data  out  8  head of read FIFO (first-word fall-through); rd_empty  out  1; rd_count  out  log2(RD_DEPTH)+1.
REQ-006 SHALL have ports: busy  out  1  operation in flight; err  out  1  sticky NACK; ovf  out  1  sticky push-while-full; err_clr  in  1  clears err and ovf.
REQ-007 SHALL have ports to the downstream byte engine: op_valid, op_start, op_stop, op_rnw  out  1 each; op_wr_data  out  8; op_rd_data  in  8; op_ack  in  1; op_err  in  1.

Function
REQ-008 SHALL run FSM states IDLE, ISSUE, WAIT_ACK; all outputs registered.
REQ-009 IDLE SHALL go to ISSUE when cmd FIFO non-empty and (head rnw=0 or read FIFO not full); otherwise stay.
REQ-010 ISSUE SHALL last exactly one cycle and ignore op_ack (downstream pulses op_ack while idle).
REQ-011 WAIT_ACK SHALL hold until op_ack=1, then return to IDLE.
REQ-012 op_valid SHALL be 1 in ISSUE and WAIT_ACK; op_start/op_stop/op_rnw/op_wr_data SHALL equal head command fields and stay stable while op_valid=1.
REQ-013 On accepted ack: pop head command; if rnw push op_rd_data to read FIFO; if op_err set err.
REQ-014 Latency: push at cycle N into empty idle queue -> op_valid=1 at N+2; ack at M -> op_valid=0 at M+1, rd_empty=0 at M+1, next op_valid earliest M+2.
REQ-015 busy SHALL be 1 whenever state is not IDLE or cmd FIFO non-empty.
REQ-016 Push while full SHALL be dropped and set ovf; pop while empty SHALL be ignored, rd_data unchanged.
REQ-017 Simultaneous push and pop on either FIFO SHALL both take effect; count unchanged, including at full (internal pop frees slot same cycle).
REQ-018 Pointers SHALL wrap modulo depth; count SHALL reach exactly depth at full.
REQ-019 err_clr coincident with a new error or overflow: set SHALL win.
REQ-020 Read commands SHALL never be issued unless a read-FIFO slot is guaranteed; no read data is ever lost.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state IDLE, both FIFOs empty, counts 0, cmd_full=0, rd_empty=1, op_valid=op_start=op_stop=op_rnw=0, op_wr_data=0, rd_data=0, busy=err=ovf=0.
REQ-022 Reset mid-operation SHALL abandon the in-flight op; bus recovery is the downstream engine's reset concern.
REQ-023 Deassertion SHALL take effect on the next rising clk; no op issued before cycle 2 after deassertion.

Configuration
REQ-024 Macro MIIC_OPQ_STATS_EN defined: add outputs ops_done out 16 (counts accepted acks) and nack_cnt out 8 (counts acks with op_err), both saturating, reset 0, cleared by err_clr (increment wins if coincident).
REQ-025 MIIC_OPQ_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-026 Shared package miic_pkg SHALL hold command field bit positions, command width (11), and FSM state encodings.
REQ-027 A sub-module miic_sync_fifo (parameterised width/depth, FWFT, count/full/empty) SHALL be instantiated twice (11-bit cmd, 8-bit read).

Verification
REQ-028 Push {start=1,stop=0,rnw=0,0xA0}, {0,1,1,0x00}; ack after 5 cycles each with op_rd_data=0x5C -> two ops in order, rd_data=0x5C, rd_count=1, err=0.
REQ-029 Fill cmd FIFO to 16, push 17th -> dropped, ovf=1, cmd_count=16; err_clr -> ovf=0.
REQ-030 RD_DEPTH=2, read FIFO full, head rnw=1 -> op_valid stays 0; pop once -> op_valid=1 two cycles later.
REQ-031 Hold op_ack=1 constantly -> exactly one pop per ISSUE/WAIT_ACK pair, no acceptance in ISSUE or IDLE.
REQ-032 op_err=1 with ack while err_clr=1 -> err=1; nack_cnt=1 with MIIC_OPQ_STATS_EN.
REQ-033 Assert rst_n=0 during WAIT_ACK with 3 queued -> outputs reach reset values immediately, cmd_count=0.
